sd_cmd_phy: RTL and testbench
=============================

Name: sd_cmd_phy

Overview:
- Serial CMD-line engine that sits directly downstream of the command controller.
- Takes a parallel command (index and argument), builds the 48-bit SD command frame with CRC7, and shifts it out on the CMD pin.
- Then waits for the card response, deserialises it (48 or 136 bits), checks it, and returns it to the controller over a valid/ack handshake.
- All timing is driven by an SD-clock enable strobe inside the single system clock domain.

Parameters:
TIMEOUT_TICKS, 64, max sd_clk_en ticks after the end bit before a response start bit must appear (NCR limit)
RESP_W, 128, width of the response output

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
sd_clk_en  input  1  one-cycle strobe; one CMD-line bit time per strobe
new_command  input  1  start request; sampled only in IDLE
cmd_index  input  6  command index
cmd_argument  input  32  command argument
resp_type  input  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy (treated as 48-bit here)
cmd_pin_in  input  1  sampled CMD line
cmd_pin_out  output  1  driven CMD bit
cmd_pin_oe  output  1  CMD drive enable
response  output  128  captured response payload
enable_response  output  1  response/status valid
ack_response  input  1  consumer acknowledge
busy  output  1  high whenever state is not IDLE
timeout_err  output  1  no start bit within TIMEOUT_TICKS
crc_err  output  1  response CRC7 mismatch
end_bit_err  output  1  response end bit was 0
index_err  output  1  see Optional Feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, using the codebase port names clock and reset.
- Reset values:
  - cmd_pin_out=1, cmd_pin_oe=0, response=0, and all flags, busy and enable_response 0.
  - State is IDLE.
  - Reset asserted mid-operation aborts immediately to these values.
- States: IDLE, SEND, WAIT_RESP, RECEIVE, DONE.
- IDLE -> SEND on new_command=1:
  - Latch cmd_index, cmd_argument and resp_type.
  - Clear all error flags.
  - new_command in any other state is ignored.
- SEND:
  - Frame is 0, 1, index[5:0], arg[31:0], crc7[6:0], 1, sent MSB first.
  - One bit per sd_clk_en; cmd_pin_oe=1 for all 48 bit times.
  - CRC7 uses polynomial x^7+x^3+1, init 0, over the first 40 bits, computed serially while shifting.
- After the end bit, cmd_pin_oe drops on the next sd_clk_en and cmd_pin_out returns to 1.
  - resp_type=00 -> DONE.
  - Otherwise -> WAIT_RESP.
- WAIT_RESP:
  - Counts sd_clk_en ticks while cmd_pin_in=1.
  - cmd_pin_in=0 on a tick -> RECEIVE; that 0 is counted as response bit 0.
  - Counter reaching TIMEOUT_TICKS -> timeout_err=1, DONE.
  - If the start bit and the final tick coincide, the start bit wins.
- RECEIVE:
  - Shift in 48 or 136 bits total, one per sd_clk_en.
  - CRC7 covers received bits 47..8 for 48-bit responses and 127..8 for 136-bit responses; the 136-bit CRC excludes the 8 header bits.
  - Compare against the received CRC field, then check the end bit.
- RECEIVE -> DONE after the last bit. Response mapping:
  - 48-bit: response[31:0] = frame[39:8], upper bits 0.
  - 136-bit: response[119:0] = frame[127:8], [127:120]=0.
- DONE:
  - enable_response=1, held along with all flags and response until ack_response=1.
  - On ack, go to IDLE on the next clock and drop enable_response.
  - If ack is high on the first DONE cycle, the DONE state lasts exactly one clock.
- Only the busy/flag outputs and enable_response change between sd_clk_en strobes; the shift, count and CRC logic advance only on sd_clk_en.
- Latency from new_command to the first bit on the pin: the first sd_clk_en after the latch clock.

Optional Feature:
- Macro: SD_CMD_INDEX_CHECK_EN.
- Defined: for 48-bit responses, received bits [45:40] are compared to the latched cmd_index; on mismatch index_err=1 in DONE.
- 136-bit responses are never index-checked.
- Not defined: index_err is tied to 0 and the comparator is not built.

Test Plan:
- CMD0, arg 0x00000000, resp_type 00 -> pin carries 0x400000000095 over 48 ticks, oe high for 48 ticks; enable_response within 2 ticks after the end bit; all flags 0.
- CMD8, arg 0x000001AA, resp_type 10 -> pin carries 0x48000001AA87; card drives 0x08000001AA13 starting 5 ticks later -> response=0x000001AA, crc_err=0, end_bit_err=0, index_err=0.
- Same as CMD8 but the card returns CRC byte 0x15 -> crc_err=1; returning byte 0x12 (end bit 0) -> end_bit_err=1 with crc_err=0.
- CMD8 with the pin held 1 after the end bit -> timeout_err=1 exactly TIMEOUT_TICKS=64 ticks later, response=0.
- Hold ack_response=0 for 20 clocks in DONE -> enable_response and response stable; a new_command pulse during DONE is ignored. Ack -> IDLE, busy=0 next clock.
- Assert reset at bit 20 of SEND -> oe=0, cmd_pin_out=1, busy=0 immediately; the next CMD0 sends the correct full frame.
- With SD_CMD_INDEX_CHECK_EN defined: response index 0x09 to CMD8 -> index_err=1.

Source files
------------

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line engine. Serialises a 48-bit command frame with CRC7,
// then captures a 48- or 136-bit card response, checks CRC7 and end bit, and
// hands the result to the controller over a valid/ack handshake.
// Build macro SD_CMD_INDEX_CHECK_EN adds the response index comparator.
module sd_cmd_phy #(
    parameter int unsigned TIMEOUT_TICKS = 64,
    parameter int unsigned RESP_W        = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sd_clk_en,
    input  logic              new_command,
    input  logic [5:0]        cmd_index,
    input  logic [31:0]       cmd_argument,
    input  logic [1:0]        resp_type,
    input  logic              cmd_pin_in,
    output logic              cmd_pin_out,
    output logic              cmd_pin_oe,
    output logic [RESP_W-1:0] response,
    output logic              enable_response,
    input  logic              ack_response,
    output logic              busy,
    output logic              timeout_err,
    output logic              crc_err,
    output logic              end_bit_err,
    output logic              index_err
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

    // The tick that drops cmd_pin_oe is the first tick after the end bit, so the
    // wait counter starts at 1 and the final tick is TIMEOUT_TICKS after the end bit.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t            state_q, state_d;
    logic [39:0]       sh_q, sh_d;
    logic [1:0]        type_q, type_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [6:0]        crc_q, crc_d;
    logic [126:0]      rx_q, rx_d;
    logic [127:0]      rx_next;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              pin_q, pin_d;
    logic              oe_q, oe_d;
    logic              tmo_err_q, tmo_err_d;
    logic              crc_err_q, crc_err_d;
    logic              end_err_q, end_err_d;
    logic              long_resp, last_bit, in_crc;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign long_resp = (type_q == 2'b01);
    assign last_bit  = (cnt_q == (long_resp ? 8'd135 : 8'd47));
    assign in_crc    = long_resp ? (cnt_q >= 8'd8 && cnt_q < 8'd128) : (cnt_q < 8'd40);
    assign rx_next   = {rx_q, cmd_pin_in};

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            type_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            crc_q     <= '0;
            rx_q      <= '0;
            resp_q    <= '0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
            tmo_err_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            resp_q    <= resp_d;
            pin_q     <= pin_d;
            oe_q      <= oe_d;
            tmo_err_q <= tmo_err_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
        end
    end

    // Next-state logic: transmit, wait for start bit, receive, hold until ack.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        resp_d    = resp_q;
        pin_d     = pin_q;
        oe_d      = oe_q;
        tmo_err_d = tmo_err_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        case (state_q)
            IDLE: begin
                if (new_command) begin
                    state_d   = SEND;
                    sh_d      = {2'b01, cmd_index, cmd_argument};
                    type_d    = resp_type;
                    cnt_d     = '0;
                    crc_d     = '0;
                    resp_d    = '0;
                    tmo_err_d = 1'b0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                end
            end
            SEND: begin
                if (sd_clk_en) begin
                    cnt_d = cnt_q + 8'd1;
                    oe_d  = 1'b1;
                    if (cnt_q < 8'd40) begin
                        pin_d = sh_q[39];
                        crc_d = crc7_step(crc_q, sh_q[39]);
                        sh_d  = {sh_q[38:0], 1'b0};
                    end else if (cnt_q < 8'd47) begin
                        pin_d = crc_q[6];
                        crc_d = {crc_q[5:0], 1'b0};
                    end else if (cnt_q == 8'd47) begin
                        pin_d = 1'b1;
                    end else begin
                        pin_d   = 1'b1;
                        oe_d    = 1'b0;
                        tmo_d   = 16'd1;
                        state_d = (type_q == 2'b00) ? DONE : WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (sd_clk_en) begin
                    if (!cmd_pin_in) begin
                        state_d = RECEIVE;
                        rx_d    = '0;
                        cnt_d   = 8'd1;
                        crc_d   = '0;
                    end else if (tmo_q == TO_LAST) begin
                        tmo_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            RECEIVE: begin
                if (sd_clk_en) begin
                    rx_d  = rx_next[126:0];
                    cnt_d = cnt_q + 8'd1;
                    if (in_crc) begin
                        crc_d = crc7_step(crc_q, cmd_pin_in);
                    end
                    if (last_bit) begin
                        state_d   = DONE;
                        crc_err_d = (crc_q != rx_next[7:1]);
                        end_err_d = !rx_next[0];
                        resp_d    = long_resp ? RESP_W'(rx_next[127:8]) : RESP_W'(rx_next[39:8]);
                    end
                end
            end
            DONE: begin
                if (ack_response) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SD_CMD_INDEX_CHECK_EN
    logic [5:0] idx_q, idx_d;
    logic       idx_err_q, idx_err_d;

    // Latched command index and response index comparison result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            idx_err_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            idx_err_q <= idx_err_d;
        end
    end

    // Compare the received index field on the last bit of a 48-bit response.
    always_comb begin
        idx_d     = idx_q;
        idx_err_d = idx_err_q;
        if (state_q == IDLE && new_command) begin
            idx_d     = cmd_index;
            idx_err_d = 1'b0;
        end else if (state_q == RECEIVE && sd_clk_en && last_bit && !long_resp) begin
            idx_err_d = (rx_next[45:40] != idx_q);
        end
    end

    assign index_err = idx_err_q;
`else
    assign index_err = 1'b0;
`endif

    assign cmd_pin_out     = pin_q;
    assign cmd_pin_oe      = oe_q;
    assign response        = resp_q;
    assign enable_response = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign timeout_err     = tmo_err_q;
    assign crc_err         = crc_err_q;
    assign end_bit_err     = end_err_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: directed and randomized checks of sd_cmd_phy against a
// polynomial-division CRC7 reference model.
module tb_sd_cmd_phy;

    localparam int TO = 64;

`ifdef SD_CMD_INDEX_CHECK_EN
    localparam bit IDX_CHK = 1'b1;
`else
    localparam bit IDX_CHK = 1'b0;
`endif

    logic         clock        = 1'b0;
    logic         reset        = 1'b1;
    logic         sd_clk_en    = 1'b0;
    logic         new_command  = 1'b0;
    logic [5:0]   cmd_index    = '0;
    logic [31:0]  cmd_argument = '0;
    logic [1:0]   resp_type    = '0;
    logic         cmd_pin_in   = 1'b1;
    logic         ack_response = 1'b0;
    logic         cmd_pin_out, cmd_pin_oe, enable_response, busy;
    logic         timeout_err, crc_err, end_bit_err, index_err;
    logic [127:0] response;

    int n_assert = 0;
    int n_fail   = 0;

    sd_cmd_phy #(.TIMEOUT_TICKS(TO), .RESP_W(128)) dut (
        .clock           (clock),
        .reset           (reset),
        .sd_clk_en       (sd_clk_en),
        .new_command     (new_command),
        .cmd_index       (cmd_index),
        .cmd_argument    (cmd_argument),
        .resp_type       (resp_type),
        .cmd_pin_in      (cmd_pin_in),
        .cmd_pin_out     (cmd_pin_out),
        .cmd_pin_oe      (cmd_pin_oe),
        .response        (response),
        .enable_response (enable_response),
        .ack_response    (ack_response),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .crc_err         (crc_err),
        .end_bit_err     (end_bit_err),
        .index_err       (index_err)
    );

    initial forever #5 clock = ~clock;

    // SD bit strobe: one clock in four, changed on the falling edge.
    initial begin
        int unsigned div;
        div = 0;
        forever begin
            @(negedge clock);
            div = (div + 1) % 4;
            sd_clk_en = (div == 0);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clock); while (!sd_clk_en);
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (message msg[n-1:0]).
    function automatic logic [6:0] crc7_div(input logic [135:0] msg, input int n);
        logic [142:0] m;
        m = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    task automatic do_ack(input string tag);
        @(negedge clock);
        ack_response = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, " busy after ack"}, busy, 1'b0);
        chk({tag, " enable after ack"}, enable_response, 1'b0);
        @(negedge clock);
        ack_response = 1'b0;
    endtask

    // Issue one command, capture the frame, play the card response, check DONE.
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input logic [135:0] card, input int dly,
                           input bit hold, output logic [47:0] tx);
        logic [47:0]  exp_tx;
        logic [127:0] exp_resp;
        logic         e_tmo, e_crc, e_end, e_idx;
        int           oe_n, len, got;
        bit           long_r;

        exp_tx   = {2'b01, idx, arg, crc7_div(136'({2'b01, idx, arg}), 40), 1'b1};
        long_r   = (rt == 2'b01);
        len      = long_r ? 136 : 48;
        exp_resp = '0;
        e_tmo = 1'b0; e_crc = 1'b0; e_end = 1'b0; e_idx = 1'b0;
        if (rt == 2'b00) begin
        end else if (hold) begin
            e_tmo = 1'b1;
        end else if (long_r) begin
            exp_resp = 128'(card[127:8]);
            e_crc    = (crc7_div(136'(card[127:8]), 120) != card[7:1]);
            e_end    = !card[0];
        end else begin
            exp_resp = 128'(card[39:8]);
            e_crc    = (crc7_div(136'(card[47:8]), 40) != card[7:1]);
            e_end    = !card[0];
            e_idx    = IDX_CHK && (card[45:40] != idx);
        end

        cmd_pin_in = 1'b1;
        @(negedge clock);
        cmd_index = idx; cmd_argument = arg; resp_type = rt; new_command = 1'b1;
        @(posedge clock);
        #1;
        new_command = 1'b0;
        tx = '0;
        oe_n = 0;
        for (int i = 0; i < 48; i++) begin
            wait_tick();
            #1;
            tx = {tx[46:0], cmd_pin_out};
            if (cmd_pin_oe === 1'b1) oe_n++;
        end
        chk({tag, " tx frame"}, tx, exp_tx);
        chk({tag, " oe bit times"}, oe_n, 48);
        wait_tick();
        #1;
        chk({tag, " oe after end"}, cmd_pin_oe, 1'b0);
        chk({tag, " pin after end"}, cmd_pin_out, 1'b1);

        if (rt == 2'b00) begin
            if (enable_response !== 1'b1) begin
                wait_tick();
                #1;
            end
        end else if (hold) begin
            got = -1;
            for (int k = 2; k <= TO + 8; k++) begin
                wait_tick();
                #1;
                if (timeout_err === 1'b1) begin
                    got = k;
                    break;
                end
            end
            chk({tag, " timeout tick"}, got, TO);
        end else begin
            for (int k = 2; k < dly; k++) begin
                wait_tick();
                #1;
            end
            for (int i = 0; i < len; i++) begin
                cmd_pin_in = card[len - 1 - i];
                wait_tick();
                #1;
            end
            cmd_pin_in = 1'b1;
        end

        chk({tag, " enable_response"}, enable_response, 1'b1);
        chk({tag, " busy in done"}, busy, 1'b1);
        chk({tag, " response"}, response, exp_resp);
        chk({tag, " timeout_err"}, timeout_err, e_tmo);
        chk({tag, " crc_err"}, crc_err, e_crc);
        chk({tag, " end_bit_err"}, end_bit_err, e_end);
        chk({tag, " index_err"}, index_err, e_idx);
    endtask

    initial begin
        logic [47:0]  tx;
        logic [127:0] hold_resp;
        logic [135:0] cf;
        logic [119:0] body;
        logic [39:0]  b48;
        logic [6:0]   crc;
        logic [5:0]   ci, ri;
        logic [31:0]  ca;
        logic [1:0]   rt;
        bit           stable, eb;
        int           d;

        // Reset values while reset is held.
        repeat (3) @(posedge clock);
        #1;
        chk("reset pin_out", cmd_pin_out, 1'b1);
        chk("reset oe", cmd_pin_oe, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset enable", enable_response, 1'b0);
        chk("reset response", response, '0);
        chk("reset flags", {timeout_err, crc_err, end_bit_err, index_err}, 4'b0);
        @(negedge clock);
        reset = 1'b0;

        // CMD0, no response.
        run_cmd("cmd0", 6'd0, 32'h0, 2'b00, '0, 0, 1'b0, tx);
        chk("cmd0 frame const", tx, 48'h400000000095);
        do_ack("cmd0");

        // CMD8 with good R7; then hold DONE for 20 clocks with a stray new_command.
        run_cmd("cmd8", 6'd8, 32'h1AA, 2'b10, 136'(48'h08000001AA13), 5, 1'b0, tx);
        chk("cmd8 frame const", tx, 48'h48000001AA87);
        chk("cmd8 response const", response, 128'h1AA);
        hold_resp = response;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            new_command = (c == 5);
            cmd_index = 6'd0;
            resp_type = 2'b00;
            @(posedge clock);
            #1;
            if (response !== hold_resp || enable_response !== 1'b1 ||
                cmd_pin_oe !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        @(negedge clock);
        new_command = 1'b0;
        chk("done hold stable", stable, 1'b1);
        do_ack("cmd8");

        // Bad CRC byte, then bad end bit.
        run_cmd("cmd8 badcrc", 6'd8, 32'h1AA, 2'b10, 136'(48'h08000001AA15), 5, 1'b0, tx);
        chk("badcrc crc_err const", crc_err, 1'b1);
        do_ack("badcrc");
        run_cmd("cmd8 badend", 6'd8, 32'h1AA, 2'b10, 136'(48'h08000001AA12), 5, 1'b0, tx);
        chk("badend flags const", {crc_err, end_bit_err}, 2'b01);
        do_ack("badend");

        // Timeout: pin never leaves 1.
        run_cmd("cmd8 timeout", 6'd8, 32'h1AA, 2'b10, '0, 0, 1'b1, tx);
        do_ack("timeout");

        // Start bit on the final permitted tick wins over timeout.
        run_cmd("cmd8 lastTick", 6'd8, 32'h1AA, 2'b11, 136'(48'h08000001AA13), TO, 1'b0, tx);
        do_ack("lastTick");

        // Response carrying the wrong index (0x09) with a valid CRC.
        b48 = {2'b00, 6'h09, 32'h1AA};
        cf  = 136'({b48, crc7_div(136'(b48), 40), 1'b1});
        run_cmd("cmd8 idx09", 6'd8, 32'h1AA, 2'b10, cf, 3, 1'b0, tx);
        do_ack("idx09");

        // Reset during bit 20 of SEND.
        @(negedge clock);
        cmd_index = 6'd8; cmd_argument = 32'h1AA; resp_type = 2'b10; new_command = 1'b1;
        @(posedge clock);
        #1;
        new_command = 1'b0;
        for (int i = 0; i < 21; i++) wait_tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset oe", cmd_pin_oe, 1'b0);
        chk("midreset pin", cmd_pin_out, 1'b1);
        chk("midreset busy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        run_cmd("cmd0 after reset", 6'd0, 32'h0, 2'b00, '0, 0, 1'b0, tx);
        chk("cmd0 after reset const", tx, 48'h400000000095);
        do_ack("cmd0 after reset");

        // Randomized commands and card responses.
        for (int t = 0; t < 8; t++) begin
            ci = 6'($urandom);
            ca = $urandom;
            rt = 2'($urandom);
            d  = 2 + int'($urandom_range(0, 38));
            eb = ($urandom_range(0, 3) != 0);
            if (rt == 2'b01) begin
                body = {24'($urandom), $urandom, $urandom, $urandom};
                crc  = crc7_div(136'(body), 120);
                if ($urandom_range(0, 3) == 0) crc = crc ^ 7'($urandom_range(1, 127));
                cf = {8'h3F, body, crc, eb};
            end else begin
                ri  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : ci;
                b48 = {2'b00, ri, 32'($urandom)};
                crc = crc7_div(136'(b48), 40);
                if ($urandom_range(0, 3) == 0) crc = crc ^ 7'($urandom_range(1, 127));
                cf = 136'({b48, crc, eb});
            end
            run_cmd($sformatf("rand%0d", t), ci, ca, rt, cf, d, 1'b0, tx);
            do_ack($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
